// File: rtl/axis_packet_merger.sv
// axis_packet_merger: merges CHANNEL_NUMBER_IN AXI-Stream inputs onto one
// output at packet granularity. A round-robin arbiter picks one input while
// idle, locks onto it until its tlast beat is accepted, and forwards beats
// through a single output register. One arbitration bubble separates packets.
module axis_packet_merger #(
    parameter int DATA_WIDTH        = 32,
    parameter int CHANNEL_NUMBER_IN = 5,
    parameter int IDX_W             = (CHANNEL_NUMBER_IN > 1) ? $clog2(CHANNEL_NUMBER_IN) : 1
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [CHANNEL_NUMBER_IN*DATA_WIDTH-1:0] s_tdata,
    input  logic [CHANNEL_NUMBER_IN-1:0]            s_tvalid,
    input  logic [CHANNEL_NUMBER_IN-1:0]            s_tlast,
    output logic [CHANNEL_NUMBER_IN-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]                   m_tdata,
    output logic                                    m_tvalid,
    output logic                                    m_tlast,
    input  logic                                    m_tready,
    output logic [IDX_W-1:0]                        grant_o,
    output logic                                    busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;

    logic [IDX_W-1:0]      pick_hi, pick_lo, pick_idx;
    logic                  found_hi, found_lo;
    logic                  gnt_tvalid, gnt_tlast;
    logic [DATA_WIDTH-1:0] gnt_tdata;
    logic                  locked, out_free, accept;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = CHANNEL_NUMBER_IN - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
                found_lo = 1'b1;
                pick_lo  = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = IDX_W'(i);
                end
            end
        end
        pick_idx = found_hi ? pick_hi : pick_lo;
    end

    // Select the locked input's valid/last/data.
    always_comb begin
        gnt_tvalid = 1'b0;
        gnt_tlast  = 1'b0;
        gnt_tdata  = '0;
        for (int i = 0; i < CHANNEL_NUMBER_IN; i++) begin
            if (grant_q == IDX_W'(i)) begin
                gnt_tvalid = s_tvalid[i];
                gnt_tlast  = s_tlast[i];
                gnt_tdata  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign locked   = (state_q == ST_LOCKED);
    assign out_free = !m_tvalid_q || m_tready;
    assign accept   = locked && out_free && gnt_tvalid;

    // Only the locked input sees ready; nothing is accepted during arbitration.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < CHANNEL_NUMBER_IN; i++) begin
            s_tready[i] = locked && out_free && (grant_q == IDX_W'(i));
        end
    end

    // Next-state logic for the arbiter FSM and the output beat register.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;

        // A held beat leaves on handshake; a same-edge capture below overrides this.
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (found_lo) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    m_tdata_d  = gnt_tdata;
                    m_tlast_d  = gnt_tlast;
                    m_tvalid_d = 1'b1;
                    if (gnt_tlast) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == IDX_W'(CHANNEL_NUMBER_IN - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    // NOTE: the output data register is reset too, so m_tdata reads 0 right after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;
    assign grant_o  = grant_q;
    assign busy_o   = locked;

endmodule
